// File: rtl/route_sel_ctrl_pkg.sv
// Shared types and constants for the route select controller.
// Holds the FSM states, the dual-rail token encodings and the default parameter values.
package route_sel_ctrl_pkg;

    localparam int DEPTH_DEF     = 4;
    localparam int CNT_W_DEF     = 8;
    localparam int TO_CYCLES_DEF = 255;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_ZERO = 2'b01;
    localparam logic [1:0] DR_ONE  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_NULL = 2'd2
    } state_t;

    function automatic logic [1:0] dr_encode(input logic bit_i);
        return bit_i ? DR_ONE : DR_ZERO;
    endfunction

endpackage

// File: rtl/route_sel_ctrl_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency: two clk_i edges; no backpressure.
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/route_sel_ctrl.sv
// Queues route requests and issues each as a dual-rail select token into a PCHB split.
// Latency: token on the first edge after the synchronised enable rises; route_ready drops only when the queue is full.
module route_sel_ctrl
    import route_sel_ctrl_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             route_valid,
    input  logic             route_dest,
    output logic             route_ready,
    output logic [1:0]       sel,
    input  logic             sele,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             err
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TO_W = $clog2(TO_CYCLES + 1);

    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [AW:0]      OCC_ONE = (AW + 1)'(1);
    localparam logic [AW:0]      OCC_MAX = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TO_CYCLES);

    logic sele_s;

    sync2 u_sele_sync (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (sele),
        .q_o   (sele_s)
    );

    // Request queue: one destination bit per entry.
    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      occ_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             head_dat;

    assign full        = (occ_q == OCC_MAX);
    assign empty       = (occ_q == '0);
    assign route_ready = !full;
    assign push        = route_valid && !full;
    assign head_dat    = mem_q[rd_ptr_q];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= route_dest;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_ONE;
                2'b01:   occ_q <= occ_q - OCC_ONE;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Handshake FSM.
    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic             head_q, head_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            sel_q    <= DR_NULL;
            head_q   <= 1'b0;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            head_q   <= head_d;
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        head_d   = head_q;
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sele_s && !empty) begin
                    pop      = 1'b1;
                    head_d   = head_dat;
                    sel_d    = dr_encode(head_dat);
                    state_d  = S_DATA;
                    to_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (!sele_s) begin
                    sel_d    = DR_NULL;
                    state_d  = S_NULL;
                    to_cnt_d = '0;
                    if (head_q) cnt1_d = cnt1_q + CNT_ONE;
                    else        cnt0_d = cnt0_q + CNT_ONE;
                end else if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            S_NULL: begin
                if (sele_s) begin
                    state_d  = S_IDLE;
                    to_cnt_d = '0;
                end else if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                sel_d    = DR_NULL;
                to_cnt_d = '0;
            end
        endcase

        // The timeout only flags a stuck split; the handshake keeps waiting.
        if (state_q != S_IDLE && state_d == state_q && to_cnt_d == TO_MAX) begin
            err_d = 1'b1;
        end
    end

    assign sel  = sel_q;
    assign busy = (state_q != S_IDLE) || !empty;
    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
    assign err  = err_q;

endmodule

// File: tb/tb_route_sel_ctrl.sv
// Directed bench for route_sel_ctrl: the bench plays the split's 4-phase sele responder.
module tb_route_sel_ctrl;
    import route_sel_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       route_valid;
    logic       route_dest;
    logic       sele;
    logic       route_ready;
    logic [1:0] sel;
    logic       busy;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic       err;

    int errors = 0;
    int checks = 0;

    route_sel_ctrl #(
        .DEPTH     (4),
        .CNT_W     (8),
        .TO_CYCLES (255)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .route_valid (route_valid),
        .route_dest  (route_dest),
        .route_ready (route_ready),
        .sel         (sel),
        .sele        (sele),
        .busy        (busy),
        .cnt0        (cnt0),
        .cnt1        (cnt1),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    // sel must never be 11 and may only move one rail between samples.
    logic [1:0] sel_prev = 2'b00;
    always @(negedge CLK) begin
        if (!RESET) begin
            checks++;
            assert (sel !== 2'b11 && $countones(sel ^ sel_prev) <= 1)
            else begin
                errors++;
                $error("FAIL sel_rail: got %b after %b, required legal single-rail step", sel, sel_prev);
            end
        end
        sel_prev = sel;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_sel(input logic [1:0] exp, input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            if (sel === exp) break;
            step(1);
        end
        chk(tag, sel, exp);
    endtask

    task automatic push(input logic d);
        route_valid = 1'b1;
        route_dest  = d;
        for (int i = 0; i < 50; i++) begin
            if (route_ready === 1'b1) break;
            step(1);
        end
        chk("push_ready", route_ready, 1);
        step(1);
        route_valid = 1'b0;
    endtask

    task automatic handle_token(input logic [1:0] exp, input string tag);
        sele = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sel !== DR_NULL) break;
            step(1);
        end
        chk(tag, sel, exp);
        sele = 1'b0;
        wait_sel(DR_NULL, 20, {tag, "_null"});
    endtask

    task automatic do_reset();
        RESET       = 1'b1;
        sele        = 1'b0;
        route_valid = 1'b0;
        route_dest  = 1'b0;
        step(2);
        RESET = 1'b0;
        step(1);
    endtask

    initial begin
        RESET       = 1'b1;
        sele        = 1'b0;
        route_valid = 1'b0;
        route_dest  = 1'b0;
        #1;
        chk("rst_sel", sel, DR_NULL);
        chk("rst_ready", route_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_err", err, 0);
        step(2);
        RESET = 1'b0;
        step(1);

        // Single token to R0 with exact edge latency.
        route_valid = 1'b1;
        route_dest  = 1'b0;
        sele        = 1'b1;
        step(1);
        route_valid = 1'b0;
        chk("t1_busy_queued", busy, 1);
        chk("t1_sel_e1", sel, DR_NULL);
        step(1);
        chk("t1_sel_e2", sel, DR_NULL);
        step(1);
        chk("t1_sel_e3", sel, DR_ZERO);
        sele = 1'b0;
        step(2);
        chk("t1_sel_hold", sel, DR_ZERO);
        step(1);
        chk("t1_sel_null", sel, DR_NULL);
        chk("t1_cnt0", cnt0, 1);
        sele = 1'b1;
        step(2);
        chk("t1_busy_null", busy, 1);
        step(1);
        chk("t1_busy_idle", busy, 0);

        // Push into empty queue while idle with sele_s high: issued next edge, not same edge.
        route_valid = 1'b1;
        route_dest  = 1'b1;
        step(1);
        route_valid = 1'b0;
        chk("nb_sel_push_edge", sel, DR_NULL);
        step(1);
        chk("nb_sel_next_edge", sel, DR_ONE);
        sele = 1'b0;
        wait_sel(DR_NULL, 10, "nb_null");
        chk("nb_cnt1", cnt1, 1);

        // Sequence 1,0,1,1 through the responder.
        do_reset();
        push(1'b1);
        push(1'b0);
        push(1'b1);
        push(1'b1);
        handle_token(DR_ONE,  "seq_t0");
        handle_token(DR_ZERO, "seq_t1");
        handle_token(DR_ONE,  "seq_t2");
        handle_token(DR_ONE,  "seq_t3");
        sele = 1'b1;
        step(4);
        chk("seq_busy", busy, 0);
        chk("seq_cnt0", cnt0, 1);
        chk("seq_cnt1", cnt1, 3);

        // Push and pop on the same edge.
        do_reset();
        push(1'b0);
        sele = 1'b1;
        step(2);
        route_valid = 1'b1;
        route_dest  = 1'b1;
        step(1);
        route_valid = 1'b0;
        chk("pp_issue", sel, DR_ZERO);
        chk("pp_busy", busy, 1);
        sele = 1'b0;
        wait_sel(DR_NULL, 10, "pp_null");
        handle_token(DR_ONE, "pp_t1");
        sele = 1'b1;
        step(4);
        chk("pp_busy_end", busy, 0);

        // Fill queue with sele low; fifth request waits for a pop.
        do_reset();
        push(1'b0);
        push(1'b1);
        push(1'b1);
        push(1'b0);
        chk("full_ready", route_ready, 0);
        route_valid = 1'b1;
        route_dest  = 1'b1;
        step(5);
        chk("full_held", route_ready, 0);
        chk("full_no_token", sel, DR_NULL);
        sele = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (route_ready === 1'b1) break;
            step(1);
        end
        chk("full_pop_ready", route_ready, 1);
        step(1);
        route_valid = 1'b0;
        chk("full_refill", route_ready, 0);
        handle_token(DR_ZERO, "full_t0");
        handle_token(DR_ONE,  "full_t1");
        handle_token(DR_ONE,  "full_t2");
        handle_token(DR_ZERO, "full_t3");
        handle_token(DR_ONE,  "full_t4");
        sele = 1'b1;
        step(4);
        chk("full_busy", busy, 0);
        chk("full_cnt0", cnt0, 2);
        chk("full_cnt1", cnt1, 3);

        // Timeout: split never consumes the token.
        do_reset();
        push(1'b1);
        sele = 1'b1;
        wait_sel(DR_ONE, 10, "to_issue");
        step(200);
        chk("to_err_early", err, 0);
        step(60);
        chk("to_err_set", err, 1);
        chk("to_sel_hold", sel, DR_ONE);
        sele = 1'b0;
        wait_sel(DR_NULL, 10, "to_complete");
        chk("to_cnt1", cnt1, 1);
        chk("to_err_sticky", err, 1);
        sele = 1'b1;
        step(4);
        chk("to_busy", busy, 0);

        // Reset in mid-handshake with a request still queued.
        push(1'b1);
        wait_sel(DR_ONE, 10, "mr_issue");
        push(1'b0);
        RESET = 1'b1;
        sele  = 1'b0;
        #1;
        chk("mr_sel", sel, DR_NULL);
        chk("mr_cnt0", cnt0, 0);
        chk("mr_cnt1", cnt1, 0);
        chk("mr_ready", route_ready, 1);
        chk("mr_err", err, 0);
        chk("mr_busy", busy, 0);
        step(2);
        RESET = 1'b0;
        step(1);

        // 256 tokens to R1: cnt1 wraps to zero.
        for (int t = 1; t <= 256; t++) begin
            push(1'b1);
            handle_token(DR_ONE, "wrap_tok");
            if (t == 255) chk("wrap_cnt1_255", cnt1, 255);
        end
        chk("wrap_cnt1_0", cnt1, 0);
        chk("wrap_cnt0", cnt0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
